// File: rtl/onehot_seq_monitor_if.sv
// onehot_seq_monitor_if
// Bundles the sample bus going into the one-hot sequence monitor and the
// status bus coming out of it.
//   master : drives en/clr/state_in/op_in, observes the status outputs
//   slave  : the monitor itself
// Signals:
//   en          sample qualifier
//   clr         synchronous clear of error, lock and counters
//   state_in    one-hot sequencer state (0001 idle .. 1000 s3)
//   op_in       sequencer op (index of the previous state)
//   locked      monitor is tracking the sequence
//   phase       index of the last accepted state
//   round_tick  one-cycle pulse per completed round
//   round_cnt   completed rounds, wraps
//   err         sticky error flag
//   err_code    first error since the last clear
interface onehot_seq_monitor_if #(
   parameter int CNT_W = 8
) ();
   logic             en;
   logic             clr;
   logic [3:0]       state_in;
   logic [1:0]       op_in;
   logic             locked;
   logic [1:0]       phase;
   logic             round_tick;
   logic [CNT_W-1:0] round_cnt;
   logic             err;
   logic [2:0]       err_code;

   modport master (
      output en, clr, state_in, op_in,
      input  locked, phase, round_tick, round_cnt, err, err_code
   );

   modport slave (
      input  en, clr, state_in, op_in,
      output locked, phase, round_tick, round_cnt, err, err_code
   );
endinterface

// File: rtl/onehot_seq_monitor.sv
// onehot_seq_monitor
// Registered checker for a 4-state one-hot sequencer (idle->s1->s2->s3->idle).
// Locks onto the sequence, checks one-hot encoding, transition order and op
// coherence, counts completed rounds and latches the first error code.
// Ports:
//   clk  clock, all updates on the rising edge
//   rst  asynchronous active-low reset
//   bus  onehot_seq_monitor_if.slave (sample inputs, status outputs)
//
// state  | meaning
// -------+-------------------------------------------------------------
// UNSYNC | waiting for an idle sample (0001) to lock onto
// TRACK  | locked; every qualified sample is classified
// ERROR  | an error was latched; samples ignored until clr or rst
module onehot_seq_monitor #(
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   onehot_seq_monitor_if.slave     bus
);

   typedef enum logic [1:0] {
      UNSYNC = 2'd0,
      TRACK  = 2'd1,
      ERROR  = 2'd2
   } mon_state_t;

   mon_state_t       st_q, st_nxt;
   logic [1:0]       prev_q, prev_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             tick_q, tick_nxt;
   logic             err_q, err_nxt;
   logic [2:0]       code_q, code_nxt;

   logic             is_onehot;
   logic [1:0]       nxt_idx;
   logic [3:0]       exp_state;

   // Sample classification helpers; nxt_idx wraps s3 -> idle naturally.
   assign is_onehot = (bus.state_in != 4'b0000) &&
                      ((bus.state_in & (bus.state_in - 4'd1)) == 4'b0000);
   assign nxt_idx   = prev_q + 2'd1;
   assign exp_state = 4'b0001 << nxt_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= UNSYNC;
         prev_q <= 2'd0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         err_q  <= 1'b0;
         code_q <= 3'b000;
      end else begin
         st_q   <= st_nxt;
         prev_q <= prev_nxt;
         cnt_q  <= cnt_nxt;
         tick_q <= tick_nxt;
         err_q  <= err_nxt;
         code_q <= code_nxt;
      end
   end

   always_comb begin
      st_nxt   = st_q;
      prev_nxt = prev_q;
      cnt_nxt  = cnt_q;
      tick_nxt = 1'b0;
      err_nxt  = err_q;
      code_nxt = code_q;

      if (bus.clr) begin
         st_nxt   = UNSYNC;
         prev_nxt = 2'd0;
         cnt_nxt  = '0;
         err_nxt  = 1'b0;
         code_nxt = 3'b000;
      end else if (bus.en) begin
         unique case (st_q)
            UNSYNC: begin
               if (bus.state_in == 4'b0001) begin
                  st_nxt   = TRACK;
                  prev_nxt = 2'd0;
               end
            end
            TRACK: begin
               // err is always clear while tracking, so the code captured
               // here is necessarily the first one since the last clear.
               if (!is_onehot) begin
                  st_nxt   = ERROR;
                  err_nxt  = 1'b1;
                  code_nxt = 3'b001;
               end else if (bus.state_in == exp_state && bus.op_in == prev_q) begin
                  prev_nxt = nxt_idx;
                  if (nxt_idx == 2'd0) begin
                     tick_nxt = 1'b1;
                     cnt_nxt  = cnt_q + CNT_W'(1);
                  end
               end else if (bus.state_in == 4'b0001 && bus.op_in == 2'b00) begin
                  prev_nxt = 2'd0;
               end else if (bus.state_in == exp_state) begin
                  st_nxt   = ERROR;
                  err_nxt  = 1'b1;
                  code_nxt = 3'b011;
               end else begin
                  st_nxt   = ERROR;
                  err_nxt  = 1'b1;
                  code_nxt = 3'b010;
               end
            end
            ERROR: begin
            end
            default: begin
               st_nxt = UNSYNC;
            end
         endcase
      end
   end

   assign bus.locked     = (st_q == TRACK);
   assign bus.phase      = prev_q;
   assign bus.round_tick = tick_q;
   assign bus.round_cnt  = cnt_q;
   assign bus.err        = err_q;
   assign bus.err_code   = code_q;

endmodule

// File: tb/tb_onehot_seq_monitor.sv
module tb_onehot_seq_monitor;
   localparam int CNT_W = 2;

   logic clk;
   logic rst;

   onehot_seq_monitor_if #(.CNT_W(CNT_W)) bus ();

   onehot_seq_monitor #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: mode 0 = unsynced, 1 = tracking, 2 = error.
   int m_mode, m_prev, m_cnt, m_tick, m_err, m_code;
   int up_prev;

   task automatic model_reset();
      m_mode = 0; m_prev = 0; m_cnt = 0; m_tick = 0; m_err = 0; m_code = 0;
   endtask

   function automatic int bit_index(logic [3:0] s);
      int ones = 0;
      int pos  = -1;
      for (int i = 0; i < 4; i++)
         if (s[i]) begin
            ones++;
            pos = i;
         end
      return (ones == 1) ? pos : -1;
   endfunction

   task automatic model_fail(int code);
      if (m_err == 0) m_code = code;
      m_err  = 1;
      m_mode = 2;
   endtask

   task automatic model_step(logic e, logic c, logic [3:0] s, logic [1:0] o);
      int k, nx;
      m_tick = 0;
      if (c) begin
         m_mode = 0; m_prev = 0; m_cnt = 0; m_err = 0; m_code = 0;
      end else if (e) begin
         if (m_mode == 0) begin
            if (s == 4'b0001) begin
               m_mode = 1;
               m_prev = 0;
            end
         end else if (m_mode == 1) begin
            k  = bit_index(s);
            nx = (m_prev + 1) % 4;
            if (k < 0) model_fail(1);
            else if (k == nx && int'(o) == m_prev) begin
               m_prev = nx;
               if (nx == 0) begin
                  m_tick = 1;
                  m_cnt  = (m_cnt + 1) % (1 << CNT_W);
               end
            end else if (k == 0 && o == 2'b00) m_prev = 0;
            else if (k == nx) model_fail(3);
            else model_fail(2);
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_all(string where);
      chk({where, ":locked"},     32'(bus.locked),     32'(m_mode == 1));
      chk({where, ":phase"},      32'(bus.phase),      32'(m_prev));
      chk({where, ":round_tick"}, 32'(bus.round_tick), 32'(m_tick));
      chk({where, ":round_cnt"},  32'(bus.round_cnt),  32'(m_cnt));
      chk({where, ":err"},        32'(bus.err),        32'(m_err));
      chk({where, ":err_code"},   32'(bus.err_code),   32'(m_code));
   endtask

   // Called at posedge+1: apply inputs, take one edge, update model, check.
   task automatic cycle(string where, logic e, logic c, logic [3:0] s, logic [1:0] o);
      bus.en = e; bus.clr = c; bus.state_in = s; bus.op_in = o;
      @(posedge clk);
      model_step(e, c, s, o);
      #1;
      check_all(where);
   endtask

   task automatic legal_step(string where);
      int nx;
      logic [3:0] one;
      one = 4'b0001;
      nx = (up_prev + 1) % 4;
      cycle(where, 1'b1, 1'b0, one << nx, 2'(up_prev));
      up_prev = nx;
   endtask

   task automatic relock(string where);
      cycle(where, 1'b1, 1'b0, 4'b0001, 2'b00);
      up_prev = 0;
   endtask

   task automatic clear(string where);
      cycle(where, 1'b0, 1'b1, 4'b0000, 2'b00);
   endtask

   initial begin
      int r;
      rst = 1'b0;
      bus.en = 1'b0; bus.clr = 1'b0; bus.state_in = 4'b0000; bus.op_in = 2'b00;
      model_reset();
      up_prev = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;

      // Nominal: three full rounds.
      relock("sync");
      chk("locked_after_sync", 32'(bus.locked), 32'd1);
      repeat (12) legal_step("nominal");
      chk("nominal_cnt", 32'(bus.round_cnt), 32'd3);
      chk("nominal_err", 32'(bus.err), 32'd0);

      // Restart from s2, then continue.
      legal_step("rs_s1");
      legal_step("rs_s2");
      relock("restart");
      chk("restart_phase", 32'(bus.phase), 32'd0);
      chk("restart_cnt",   32'(bus.round_cnt), 32'd3);
      repeat (4) legal_step("after_restart");
      chk("after_restart_cnt", 32'(bus.round_cnt), 32'd0);

      // en=0 with garbage: nothing moves.
      repeat (5) cycle("gated", 1'b0, 1'b0, 4'($urandom), 2'($urandom));
      chk("gated_phase", 32'(bus.phase), 32'd0);

      // Error 001: not one-hot.
      cycle("err001", 1'b1, 1'b0, 4'b0110, 2'b00);
      chk("err001_code", 32'(bus.err_code), 32'd1);

      // Error 011: correct order, wrong op.
      clear("clr1");
      relock("relock1");
      legal_step("e3_s1");
      cycle("err011", 1'b1, 1'b0, 4'b0100, 2'b11);
      chk("err011_code", 32'(bus.err_code), 32'd3);

      // Error 010: skip; later samples must not overwrite the code.
      clear("clr2");
      relock("relock2");
      legal_step("e2_s1");
      cycle("err010", 1'b1, 1'b0, 4'b1000, 2'b01);
      chk("err010_code", 32'(bus.err_code), 32'd2);
      cycle("err_hold", 1'b1, 1'b0, 4'b0110, 2'b00);
      repeat (4) cycle("err_garbage", 1'b1, 1'b0, 4'($urandom), 2'($urandom));
      chk("err_code_kept", 32'(bus.err_code), 32'd2);

      // clr beats a simultaneous illegal sample.
      clear("clr3");
      relock("relock3");
      cycle("clr_vs_err", 1'b1, 1'b1, 4'b0110, 2'b00);
      chk("clr_vs_err_err",    32'(bus.err), 32'd0);
      chk("clr_vs_err_locked", 32'(bus.locked), 32'd0);

      // Wrap: five rounds with a 2-bit counter.
      relock("relock4");
      repeat (20) legal_step("wrap");
      chk("wrap_cnt", 32'(bus.round_cnt), 32'd1);

      // Randomized mix of legal traffic, restarts, gating, garbage and clears.
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3)       clear("rnd_clr");
         else if (r < 15) cycle("rnd_gated", 1'b0, 1'b0, 4'($urandom), 2'($urandom));
         else if (r < 20) cycle("rnd_garbage", 1'b1, 1'b0, 4'($urandom), 2'($urandom));
         else if (r < 24) relock("rnd_restart");
         else             legal_step("rnd_legal");
      end

      // Asynchronous reset in the middle of a round at s2.
      clear("clr4");
      relock("relock5");
      legal_step("ar_s1");
      legal_step("ar_s2");
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("async_rst_hold");
      rst = 1'b1;
      cycle("post_rst_s3", 1'b1, 1'b0, 4'b1000, 2'b10);
      chk("post_rst_unlocked", 32'(bus.locked), 32'd0);
      relock("post_rst_sync");
      chk("post_rst_locked", 32'(bus.locked), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/onehot_seq_monitor.md
# onehot_seq_monitor

Registered checker that sits directly downstream of the 4-state one-hot sequencer (idle→s1→s2→s3→idle, one-hot `state` plus 2-bit `op`) and consumes both buses every cycle. It locks onto the sequence, verifies one-hot encoding, transition order and `op` coherence, counts completed rounds, and raises a sticky error with a first-error code. Its outputs feed status and debug logic.

## Interface
- `CNT_W`, 8, width of `round_cnt` (≥2)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-low (asserts immediately when 0, releases synchronously to `clk` by the driver)
- `en`  in  1  sample qualifier; `state_in`/`op_in` are checked only on edges where `en`=1
- `clr`  in  1  synchronous clear of error, lock and counters
- `state_in`  in  4  one-hot sequencer state (0001 idle, 0010 s1, 0100 s2, 1000 s3)
- `op_in`  in  2  sequencer op output
- `locked`  out  1  monitor is in TRACK
- `phase`  out  2  binary index of the last accepted state (idle=0 … s3=3)
- `round_tick`  out  1  one-cycle pulse per completed round
- `round_cnt`  out  CNT_W  completed rounds, wraps
- `err`  out  1  sticky error flag
- `err_code`  out  3  code of the first error since the last clear

## Operation
- Expected sequencer behaviour: `op_in` equals the binary index of the previous state. Immediately after sequencer reset, `state_in`=0001 with `op_in`=00.
- Internal FSM, 3 states: UNSYNC, TRACK, ERROR. `prev` register (2-bit index) holds the last accepted state.
- UNSYNC: on a sample with `state_in`=0001, set `prev`=0 and `phase`=0, then go to TRACK. `op_in` is ignored. Any other value is ignored and raises no error.
- TRACK: each sample is classified in priority order:
  1. `state_in` not exactly one bit set → error code 001.
  2. `state_in` = rotate-left(prev) and `op_in` = prev → normal advance. Update `prev`/`phase`. If the new state is idle (s3→idle, op 11): pulse `round_tick` and increment `round_cnt` modulo 2^CNT_W.
  3. `state_in` = 0001 and `op_in` = 00 → restart (upstream reset), legal from any `prev`. Set `prev`=0; no round counted.
  4. `state_in` = rotate-left(prev) but `op_in` ≠ prev → error code 011.
  5. Anything else (hold, skip, backward) → error code 010.
- Error: set `err`=1 and capture `err_code` (first error only), then go to ERROR. `phase` and `round_cnt` freeze.
- ERROR: all samples are ignored; only `clr` or `rst` leaves this state.
- `clr`=1: regardless of `en`, go to UNSYNC, `err`=0, `err_code`=000, `round_cnt`=0, `phase`=0. The sample in that cycle is discarded.
- `en`=0: all registers hold, and `round_tick` goes to 0.
- Reset values: UNSYNC, `locked`=0, `phase`=00, `round_tick`=0, `round_cnt`=0, `err`=0, `err_code`=000.

## Timing
- All outputs are registered. A sample accepted on edge N is reflected in outputs after edge N (latency 1 cycle).
- `round_tick` is high for exactly the one cycle after the accepting edge.
- `locked` rises the cycle after the sync sample and falls the cycle after an error or `clr`.
- Back-to-back samples are supported every cycle, so one round takes 4 consecutive `en` cycles.
- An asynchronous `rst` assertion mid-round clears everything at once. The first sample after release is treated as in UNSYNC.
- If `clr` and an error occur on the same edge, `clr` wins: no error is recorded.
- `round_cnt` wraps from 2^CNT_W−1 to 0, with `round_tick` still pulsing.

## Test plan
- Nominal: reset, then drive the sequencer pattern for 3 rounds with `en`=1 → `locked`=1 one cycle after first idle, `round_tick` pulses 3 times (on each s3→idle), `round_cnt`=3, `err`=0.
- Restart: in TRACK at s2, drive `state_in`=0001 with `op_in`=00 → no error, `phase`=0, `round_cnt` unchanged. Continuing the normal sequence is then accepted.
- Error codes:
  - `state_in`=0110 → `err`=1, `err_code`=001.
  - After `clr` and relock, s1 followed by s2 with `op_in`=11 → `err_code`=011.
  - After another `clr` and relock, s1 followed by s3 → `err_code`=010. Later errors do not overwrite the code.
- Gating and precedence:
  - `en`=0 for 5 cycles with garbage on the inputs → no change.
  - `clr` asserted together with an illegal sample → `err`=0 and monitor in UNSYNC.
- Wrap and async reset:
  - With CNT_W=2, 5 rounds → `round_cnt`=1.
  - Assert `rst`=0 mid-cycle at s2 → all outputs at reset values before the next edge.
